// File: rtl/ahb_cmd_sequencer.sv
// ahb_cmd_sequencer: queues upstream commands in a small FIFO and replays them
// one at a time onto a simple AHB-style strobe interface. Each transaction holds
// enable for a fixed number of cycles, then captures the read data and presents
// it as a response that must be accepted before the next command is issued.
module ahb_cmd_sequencer #(
  parameter int DEPTH      = 4,
  parameter int TXN_CYCLES = 3
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [31:0]             cmd_addr,
  input  logic                    cmd_wr,
  input  logic [1:0]              cmd_slave,
  input  logic [31:0]             cmd_dina,
  input  logic [31:0]             cmd_dinb,
  output logic                    enable,
  output logic [31:0]             addr,
  output logic                    wr,
  output logic [1:0]              slave_sel,
  output logic [31:0]             dina,
  output logic [31:0]             dinb,
  input  logic [31:0]             dout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic                    rsp_wr,
  output logic [1:0]              rsp_slave,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (TXN_CYCLES > 1) ? $clog2(TXN_CYCLES) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TXN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  slave;
    logic [31:0] dina;
    logic [31:0] dinb;
  } cmd_t;

  // Command storage and FIFO bookkeeping
  cmd_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             cmd_ready_s;
  logic             push_s;
  logic             pop_s;
  cmd_t             cmd_in_s;
  cmd_t             head_s;

  // Sequencer control
  state_t           state_r;
  state_t           state_nxt_s;
  logic             complete_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             enable_nxt_s;
  logic             rsp_valid_nxt_s;

  // Registered outputs
  logic             enable_r;
  logic [31:0]      addr_r;
  logic             wr_r;
  logic [1:0]       slave_sel_r;
  logic [31:0]      dina_r;
  logic [31:0]      dinb_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_data_r;
  logic             rsp_wr_r;
  logic [1:0]       rsp_slave_r;

  // Full is judged on the registered level, so a push can never overrun the FIFO
  assign cmd_ready_s = (level_r != FULL_LVL);
  assign push_s      = cmd_valid && cmd_ready_s;
  assign head_s      = mem_r[rd_ptr_r];

  // Pack the incoming command fields into one FIFO entry
  always_comb begin
    cmd_in_s       = '0;
    cmd_in_s.addr  = cmd_addr;
    cmd_in_s.wr    = cmd_wr;
    cmd_in_s.slave = cmd_slave;
    cmd_in_s.dina  = cmd_dina;
    cmd_in_s.dinb  = cmd_dinb;
  end

  // FIFO storage write; stale entries are harmless because pointers gate them
  always_ff @(posedge hclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= cmd_in_s;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointers wrap naturally
  always_ff @(posedge hclk) begin
    if (hreset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; pops only look at the level before any same-edge push
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (level_r != LVL_W'(0)) begin
          state_nxt_s = ST_ISSUE;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = ST_RESP;
          complete_s  = 1'b1;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (level_r != LVL_W'(0)) begin
            state_nxt_s = ST_ISSUE;
            pop_s       = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: strobes follow the next state so they appear registered with it
  always_comb begin
    enable_nxt_s    = (state_nxt_s == ST_ISSUE);
    rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
    if (pop_s) begin
      cnt_nxt_s = '0;
    end else if ((state_r == ST_ISSUE) && !complete_s) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Transaction counter and strobe registers
  always_ff @(posedge hclk) begin
    if (hreset) begin
      cnt_r       <= '0;
      enable_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      enable_r    <= enable_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
    end
  end

  // Command outputs load on issue and hold otherwise; response captured on completion
  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr_r      <= '0;
      wr_r        <= 1'b0;
      slave_sel_r <= '0;
      dina_r      <= '0;
      dinb_r      <= '0;
      rsp_data_r  <= '0;
      rsp_wr_r    <= 1'b0;
      rsp_slave_r <= '0;
    end else begin
      if (pop_s) begin
        addr_r      <= head_s.addr;
        wr_r        <= head_s.wr;
        slave_sel_r <= head_s.slave;
        dina_r      <= head_s.dina;
        dinb_r      <= head_s.dinb;
      end
      if (complete_s) begin
        rsp_data_r  <= wr_r ? 32'h0000_0000 : dout;
        rsp_wr_r    <= wr_r;
        rsp_slave_r <= slave_sel_r;
      end
    end
  end

  assign cmd_ready  = cmd_ready_s;
  assign fifo_level = level_r;
  assign enable     = enable_r;
  assign addr       = addr_r;
  assign wr         = wr_r;
  assign slave_sel  = slave_sel_r;
  assign dina       = dina_r;
  assign dinb       = dinb_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_wr     = rsp_wr_r;
  assign rsp_slave  = rsp_slave_r;

endmodule

// File: tb/tb_ahb_cmd_sequencer.sv
// Directed self-checking bench for ahb_cmd_sequencer (DEPTH=4, TXN_CYCLES=3).
// The AHB system is modelled as a data source that returns either a fixed
// word or addr + 0x1000_0000, so every expected response is derived here.
module tb_ahb_cmd_sequencer;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_wr;
  logic [1:0]  cmd_slave;
  logic [31:0] cmd_dina;
  logic [31:0] cmd_dinb;
  logic        enable;
  logic [31:0] addr;
  logic        wr;
  logic [1:0]  slave_sel;
  logic [31:0] dina;
  logic [31:0] dinb;
  logic [31:0] dout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_wr;
  logic [1:0]  rsp_slave;
  logic [2:0]  fifo_level;

  logic [31:0] dout_fixed;
  logic        dout_from_addr;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          overlap_cnt  = 0;

  ahb_cmd_sequencer #(.DEPTH(4), .TXN_CYCLES(3)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wr(cmd_wr), .cmd_slave(cmd_slave), .cmd_dina(cmd_dina), .cmd_dinb(cmd_dinb),
    .enable(enable), .addr(addr), .wr(wr), .slave_sel(slave_sel),
    .dina(dina), .dinb(dinb), .dout(dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_wr(rsp_wr), .rsp_slave(rsp_slave), .fifo_level(fifo_level)
  );

  always #5 hclk = ~hclk;

  assign dout = dout_from_addr ? (addr + 32'h1000_0000) : dout_fixed;

  // enable and rsp_valid must never be high together
  always @(negedge hclk) begin
    if (enable === 1'b1 && rsp_valid === 1'b1) overlap_cnt++;
  end

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_cmd(input logic [31:0] a, input logic w, input logic [1:0] s,
                           input logic [31:0] da, input logic [31:0] db);
    cmd_valid = 1'b1; cmd_addr = a; cmd_wr = w; cmd_slave = s; cmd_dina = da; cmd_dinb = db;
  endtask

  task automatic push_one(input logic [31:0] a, input logic w, input logic [1:0] s,
                          input logic [31:0] da, input logic [31:0] db);
    drive_cmd(a, w, s, da, db);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_rsp_timeout: rsp_valid=%b after %0d cycles, required 1", tag, rsp_valid, n);
    end
  endtask

  task automatic test_reset;
    hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wr = 1'b0; cmd_slave = '0;
    cmd_dina = '0; cmd_dinb = '0; rsp_ready = 1'b0; dout_fixed = '0; dout_from_addr = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({enable, rsp_valid, fifo_level} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: enable/rsp_valid/level=%b, required 00000", {enable, rsp_valid, fifo_level});
    end
    tests_run++;
    if ({addr, wr, slave_sel, dina, dinb} !== 99'b0) begin
      tests_failed++;
      $display("FAIL reset_cmd_out: addr=%h wr=%b slave=%0d dina=%h dinb=%h, required all 0", addr, wr, slave_sel, dina, dinb);
    end
    tests_run++;
    if ({rsp_data, rsp_wr, rsp_slave} !== 35'b0) begin
      tests_failed++;
      $display("FAIL reset_rsp_out: data=%h wr=%b slave=%0d, required all 0", rsp_data, rsp_wr, rsp_slave);
    end
    hreset = 1'b0;
    tick();
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_single_read;
    int k;
    int en_cycles;
    dout_from_addr = 1'b0; dout_fixed = 32'hCAFE_0001; rsp_ready = 1'b0;
    push_one(32'h10, 1'b0, 2'd2, 32'h0, 32'h0);
    tests_run++;
    if ({enable, fifo_level} !== {1'b0, 3'd1}) begin
      tests_failed++;
      $display("FAIL read_after_push: enable=%b level=%0d, required enable=0 level=1", enable, fifo_level);
    end
    en_cycles = 0;
    for (k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        tests_run++;
        if ({enable, addr, wr, slave_sel, fifo_level} !== {1'b1, 32'h10, 1'b0, 2'd2, 3'd0}) begin
          tests_failed++;
          $display("FAIL read_issue: enable=%b addr=%h wr=%b slave=%0d level=%0d, required 1/10/0/2/0", enable, addr, wr, slave_sel, fifo_level);
        end
      end
      if (rsp_valid === 1'b1) break;
      if (enable === 1'b1) en_cycles++;
    end
    tests_run++;
    if (k !== 4 || en_cycles !== 3) begin
      tests_failed++;
      $display("FAIL read_timing: rsp_valid at cycle %0d with %0d enable cycles, required cycle 4 with 3", k, en_cycles);
    end
    tests_run++;
    if ({rsp_data, rsp_wr, rsp_slave, enable} !== {32'hCAFE_0001, 1'b0, 2'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL read_rsp: data=%h wr=%b slave=%0d enable=%b, required cafe0001/0/2/0", rsp_data, rsp_wr, rsp_slave, enable);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_accept: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_write;
    dout_from_addr = 1'b0; dout_fixed = 32'hDEAD_BEEF; rsp_ready = 1'b0;
    push_one(32'h20, 1'b1, 2'd1, 32'd5, 32'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({enable, wr, addr, dina, dinb} !== {1'b1, 1'b1, 32'h20, 32'd5, 32'd7}) begin
        tests_failed++;
        $display("FAIL write_hold_%0d: enable=%b wr=%b addr=%h dina=%0d dinb=%0d, required 1/1/20/5/7", i, enable, wr, addr, dina, dinb);
      end
    end
    tick();
    tests_run++;
    if ({rsp_valid, enable, rsp_wr, rsp_slave, rsp_data} !== {1'b1, 1'b0, 1'b1, 2'd1, 32'h0}) begin
      tests_failed++;
      $display("FAIL write_rsp: valid=%b enable=%b wr=%b slave=%0d data=%h, required 1/0/1/1/0", rsp_valid, enable, rsp_wr, rsp_slave, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_fill;
    logic [2:0] exp_lvl [5];
    int idx;
    exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    dout_from_addr = 1'b1; rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(32'h100 + 32'(4 * i), 1'b0, 2'(i), 32'h0, 32'h0);
      tick();
      tests_run++;
      if (fifo_level !== exp_lvl[i]) begin
        tests_failed++;
        $display("FAIL fill_level_%0d: got %0d, required %0d", i, fifo_level, exp_lvl[i]);
      end
    end
    cmd_valid = 1'b0;
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_cmd_ready: got %b at level 4, required 0", cmd_ready);
    end
    rsp_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 100 && idx < 5; cyc++) begin
      if (rsp_valid === 1'b1) begin
        tests_run++;
        if ({rsp_data, rsp_slave} !== {exp_read(32'h100 + 32'(4 * idx)), 2'(idx)}) begin
          tests_failed++;
          $display("FAIL fill_order_%0d: data=%h slave=%0d, required %h/%0d", idx, rsp_data, rsp_slave, exp_read(32'h100 + 32'(4 * idx)), idx);
        end
        idx++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    tests_run++;
    if (idx !== 5 || fifo_level !== 3'd0) begin
      tests_failed++;
      $display("FAIL fill_drain: %0d responses level=%0d, required 5 responses level 0", idx, fifo_level);
    end
  endtask

  task automatic test_backpressure;
    dout_from_addr = 1'b1; rsp_ready = 1'b0;
    push_one(32'h300, 1'b0, 2'd3, 32'h0, 32'h0);
    push_one(32'h304, 1'b1, 2'd0, 32'hAA, 32'hBB);
    wait_rsp("bp_first");
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if ({rsp_valid, enable, rsp_data, rsp_slave} !== {1'b1, 1'b0, exp_read(32'h300), 2'd3}) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: valid=%b enable=%b data=%h slave=%0d, required 1/0/%h/3", i, rsp_valid, enable, rsp_data, rsp_slave, exp_read(32'h300));
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests_run++;
    if ({enable, rsp_valid, addr, dina, dinb} !== {1'b1, 1'b0, 32'h304, 32'hAA, 32'hBB}) begin
      tests_failed++;
      $display("FAIL bp_back_to_back: enable=%b valid=%b addr=%h dina=%h dinb=%h, required 1/0/304/aa/bb", enable, rsp_valid, addr, dina, dinb);
    end
    wait_rsp("bp_second");
    tests_run++;
    if ({rsp_wr, rsp_data} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL bp_second_rsp: wr=%b data=%h, required 1/0", rsp_wr, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_push_pop_wrap;
    logic [31:0] exp_a [3];
    logic [34:0] exp_rsp [9];
    int idx;
    int pi;
    int ri;
    logic acc;
    dout_from_addr = 1'b1; rsp_ready = 1'b0;
    push_one(32'h400, 1'b0, 2'd0, 32'h0, 32'h0);
    push_one(32'h404, 1'b0, 2'd1, 32'h0, 32'h0);
    push_one(32'h408, 1'b0, 2'd2, 32'h0, 32'h0);
    wait_rsp("pp_first");
    tests_run++;
    if ({fifo_level, rsp_data} !== {3'd2, exp_read(32'h400)}) begin
      tests_failed++;
      $display("FAIL pp_setup: level=%0d data=%h, required 2/%h", fifo_level, rsp_data, exp_read(32'h400));
    end
    drive_cmd(32'h40C, 1'b0, 2'd3, 32'h0, 32'h0);
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tests_run++;
    if ({fifo_level, enable, addr} !== {3'd2, 1'b1, 32'h404}) begin
      tests_failed++;
      $display("FAIL pp_level: level=%0d enable=%b addr=%h, required 2/1/404", fifo_level, enable, addr);
    end
    exp_a = '{32'h404, 32'h408, 32'h40C};
    idx = 0;
    for (int cyc = 0; cyc < 100 && idx < 3; cyc++) begin
      if (rsp_valid === 1'b1) begin
        tests_run++;
        if (rsp_data !== exp_read(exp_a[idx])) begin
          tests_failed++;
          $display("FAIL pp_order_%0d: data=%h, required %h", idx, rsp_data, exp_read(exp_a[idx]));
        end
        idx++;
      end
      tick();
    end
    tests_run++;
    if (idx !== 3) begin
      tests_failed++;
      $display("FAIL pp_drain: got %0d responses, required 3", idx);
    end
    // nine commands streamed through a four-entry FIFO, mixing reads and writes
    for (int i = 0; i < 9; i++) begin
      exp_rsp[i] = {(i % 3 == 2) ? 1'b1 : 1'b0, 2'(i),
                    (i % 3 == 2) ? 32'h0 : exp_read(32'h500 + 32'(4 * i))};
    end
    pi = 0; ri = 0;
    for (int cyc = 0; cyc < 300 && ri < 9; cyc++) begin
      if (rsp_valid === 1'b1 && ri < 9) begin
        tests_run++;
        if ({rsp_wr, rsp_slave, rsp_data} !== exp_rsp[ri]) begin
          tests_failed++;
          $display("FAIL wrap_order_%0d: got %h, required %h", ri, {rsp_wr, rsp_slave, rsp_data}, exp_rsp[ri]);
        end
        ri++;
      end
      if (pi < 9) drive_cmd(32'h500 + 32'(4 * pi), (pi % 3 == 2) ? 1'b1 : 1'b0, 2'(pi), 32'(pi), 32'(pi + 100));
      else cmd_valid = 1'b0;
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) pi++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    tests_run++;
    if (ri !== 9 || pi !== 9) begin
      tests_failed++;
      $display("FAIL wrap_count: pushed %0d returned %0d, required 9/9", pi, ri);
    end
    tick();
  endtask

  task automatic test_reset_midflight;
    int bad;
    dout_from_addr = 1'b1; rsp_ready = 1'b0;
    push_one(32'h600, 1'b0, 2'd0, 32'h0, 32'h0);
    push_one(32'h604, 1'b0, 2'd1, 32'h0, 32'h0);
    push_one(32'h608, 1'b0, 2'd2, 32'h0, 32'h0);
    push_one(32'h60C, 1'b0, 2'd3, 32'h0, 32'h0);
    wait_rsp("mid_first");
    drive_cmd(32'h610, 1'b0, 2'd0, 32'h0, 32'h0);
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tests_run++;
    if ({enable, fifo_level, addr} !== {1'b1, 3'd3, 32'h604}) begin
      tests_failed++;
      $display("FAIL mid_setup: enable=%b level=%0d addr=%h, required 1/3/604", enable, fifo_level, addr);
    end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    tests_run++;
    if ({enable, rsp_valid, fifo_level, cmd_ready, addr} !== {1'b0, 1'b0, 3'd0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL mid_reset: enable=%b valid=%b level=%0d ready=%b addr=%h, required 0/0/0/1/0", enable, rsp_valid, fifo_level, cmd_ready, addr);
    end
    rsp_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || enable !== 1'b0) bad++;
    end
    rsp_ready = 1'b0;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL mid_no_response: %0d cycles with activity after reset, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_fill();
    test_backpressure();
    test_push_pop_wrap();
    test_reset_midflight();
    tests_run++;
    if (overlap_cnt !== 0) begin
      tests_failed++;
      $display("FAIL enable_rsp_overlap: %0d cycles with both high, required 0", overlap_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
